// File: rtl/br_pkg.sv
// Shared branch-resolution types: funct3 encodings, controller states, taken decode.
// Pure declarations; no latency or flow control of its own.
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } br_state_t;

  // Reserved encodings 010/011 fall to the default and are never taken.
  function automatic logic br_taken(input logic [2:0] funct3,
                                    input logic       less,
                                    input logic       equal);
    logic t;
    case (funct3)
      F3_BEQ:           t = equal;
      F3_BNE:           t = !equal;
      F3_BLT, F3_BLTU:  t = less;
      F3_BGE, F3_BGEU:  t = !less;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Registered output, one cycle after inc; cleared only by reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/br_ctrl.sv
// EX-stage branch controller: operand-wait stall, taken decision, PC redirect and flush.
// Decision is combinational in the resolving cycle; only state and counters are registered.
module br_ctrl
  import br_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_WAIT     = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid_i,
  input  logic             jump_i,
  input  logic [2:0]       funct3_i,
  input  logic             opnd_busy_i,
  input  logic             kill_i,
  input  logic             br_less_i,
  input  logic             br_equal_i,
  output logic             br_unsigned_o,
  output logic             stall_o,
  output logic             pc_sel_o,
  output logic             flush_o,
  output logic             illegal_o,
  output logic             hazard_err_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  br_state_t  state;
  logic [3:0] wait_cnt;
  logic [2:0] flush_rem;

  logic req;
  logic cond_taken;
  logic f3_illegal;
  logic resolve;
  logic timeout;
  logic go_flush;
  logic inc_branch;
  logic inc_taken;

  assign req        = br_valid_i | jump_i;
  assign cond_taken = jump_i | br_taken(funct3_i, br_less_i, br_equal_i);
  assign f3_illegal = !jump_i && (funct3_i[2:1] == 2'b01);

  assign br_unsigned_o = funct3_i[1] & ~rst;

  always_comb begin
    stall_o      = 1'b0;
    pc_sel_o     = 1'b0;
    flush_o      = 1'b0;
    illegal_o    = 1'b0;
    hazard_err_o = 1'b0;
    resolve      = 1'b0;
    timeout      = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          if (opnd_busy_i) stall_o = 1'b1;
          else             resolve = 1'b1;
        end
      end
      WAIT: begin
        if (req) begin
          if (!opnd_busy_i)                 resolve = 1'b1;
          else if (wait_cnt >= 4'(MAX_WAIT)) timeout = 1'b1;
          else                              stall_o = 1'b1;
        end
      end
      FLUSH:   flush_o = 1'b1;
      default: ;
    endcase

    if (resolve) begin
      pc_sel_o  = cond_taken;
      flush_o   = cond_taken;
      illegal_o = f3_illegal;
    end
    hazard_err_o = timeout;

    // Kill squashes the whole cycle, including any resolution happening in it.
    if (kill_i) begin
      stall_o      = 1'b0;
      pc_sel_o     = 1'b0;
      illegal_o    = 1'b0;
      hazard_err_o = 1'b0;
      flush_o      = 1'b1;
    end

    if (rst) begin
      stall_o      = 1'b0;
      pc_sel_o     = 1'b0;
      flush_o      = 1'b0;
      illegal_o    = 1'b0;
      hazard_err_o = 1'b0;
    end
  end

  assign go_flush   = resolve && cond_taken && (FLUSH_CYCLES > 1);
  assign inc_branch = !kill_i && (resolve || timeout);
  assign inc_taken  = !kill_i && resolve && cond_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      flush_rem <= '0;
    end else if (kill_i) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      flush_rem <= '0;
    end else begin
      case (state)
        IDLE, WAIT: begin
          if (req && opnd_busy_i && (state == IDLE)) begin
            state    <= WAIT;
            wait_cnt <= 4'd1;
          end else if (stall_o) begin
            wait_cnt <= wait_cnt + 4'd1;
          end else if (go_flush) begin
            state     <= FLUSH;
            flush_rem <= 3'(FLUSH_CYCLES - 1);
            wait_cnt  <= '0;
          end else begin
            state    <= IDLE;
            wait_cnt <= '0;
          end
        end
        FLUSH: begin
          if (flush_rem <= 3'd1) begin
            state     <= IDLE;
            flush_rem <= '0;
          end else begin
            flush_rem <= flush_rem - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  jump_excl_a: assert property (@(posedge clk) disable iff (rst) !(br_valid_i && jump_i));

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_branch),
    .cnt (branch_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_taken),
    .cnt (taken_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_o),
    .cnt (stall_cnt_o)
  );

endmodule

// File: tb/tb_br_ctrl.sv
// Directed bench for br_ctrl: default instance plus a CNT_W=4, FLUSH_CYCLES=1 instance for saturation.
module tb_br_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       br_valid = 1'b0, jump = 1'b0, busy = 1'b0, kill = 1'b0;
  logic       less = 1'b0, equal = 1'b0;
  logic [2:0] funct3 = 3'b000;

  logic        br_unsigned, stall, pc_sel, flush, illegal, hazard;
  logic [31:0] branch_cnt, taken_cnt, stall_cnt;

  logic        j2 = 1'b0;
  logic        zero2 = 1'b0;
  logic [2:0]  f3_2 = 3'b000;
  logic        br_unsigned2, stall2, pc_sel2, flush2, illegal2, hazard2;
  logic [3:0]  branch_cnt2, taken_cnt2, stall_cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  // Packed order: {stall, pc_sel, flush, illegal, hazard, br_unsigned}
  wire [5:0] o1 = {stall, pc_sel, flush, illegal, hazard, br_unsigned};
  wire [5:0] o2 = {stall2, pc_sel2, flush2, illegal2, hazard2, br_unsigned2};

  always #5 clk = ~clk;

  br_ctrl dut (
    .clk(clk), .rst(rst), .br_valid_i(br_valid), .jump_i(jump), .funct3_i(funct3),
    .opnd_busy_i(busy), .kill_i(kill), .br_less_i(less), .br_equal_i(equal),
    .br_unsigned_o(br_unsigned), .stall_o(stall), .pc_sel_o(pc_sel), .flush_o(flush),
    .illegal_o(illegal), .hazard_err_o(hazard), .branch_cnt_o(branch_cnt),
    .taken_cnt_o(taken_cnt), .stall_cnt_o(stall_cnt)
  );

  br_ctrl #(.FLUSH_CYCLES(1), .MAX_WAIT(4), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .br_valid_i(zero2), .jump_i(j2), .funct3_i(f3_2),
    .opnd_busy_i(zero2), .kill_i(zero2), .br_less_i(zero2), .br_equal_i(zero2),
    .br_unsigned_o(br_unsigned2), .stall_o(stall2), .pc_sel_o(pc_sel2), .flush_o(flush2),
    .illegal_o(illegal2), .hazard_err_o(hazard2), .branch_cnt_o(branch_cnt2),
    .taken_cnt_o(taken_cnt2), .stall_cnt_o(stall_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic bv, input logic jmp, input logic [2:0] f3,
                       input logic bsy, input logic lt, input logic eq, input logic kl);
    @(negedge clk);
    br_valid = bv; jump = jmp; funct3 = f3; busy = bsy; less = lt; equal = eq; kill = kl;
    #1;
  endtask

  initial begin
    #1;
    chk("reset_outs", 32'(o1), 32'b000000);
    chk("reset_bcnt", branch_cnt, 32'd0);
    chk("reset_tcnt", taken_cnt, 32'd0);
    chk("reset_scnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // BEQ taken, two flush cycles
    drive(1, 0, 3'b000, 0, 0, 1, 0);
    chk("beq_resolve", 32'(o1), 32'b011000);
    drive(0, 0, 3'b000, 0, 0, 0, 0);
    chk("beq_flush2", 32'(o1), 32'b001000);
    chk("beq_bcnt", branch_cnt, 32'd1);
    chk("beq_tcnt", taken_cnt, 32'd1);
    drive(0, 0, 3'b000, 0, 0, 0, 0);
    chk("beq_idle", 32'(o1), 32'b000000);

    // BLTU / BLT not taken
    drive(1, 0, 3'b110, 0, 0, 0, 0);
    chk("bltu_nt", 32'(o1), 32'b000001);
    drive(1, 0, 3'b100, 0, 0, 0, 0);
    chk("blt_signed", 32'(o1), 32'b000000);

    // BGE with two operand-wait cycles
    drive(1, 0, 3'b101, 1, 0, 0, 0);
    chk("bge_wait1", 32'(o1), 32'b100000);
    drive(1, 0, 3'b101, 1, 0, 0, 0);
    chk("bge_wait2", 32'(o1), 32'b100000);
    drive(1, 0, 3'b101, 0, 0, 0, 0);
    chk("bge_resolve", 32'(o1), 32'b011000);
    drive(0, 0, 3'b000, 0, 0, 0, 0);
    chk("bge_flush2", 32'(o1), 32'b001000);
    chk("bge_scnt", stall_cnt, 32'd2);
    chk("bge_bcnt", branch_cnt, 32'd4);
    chk("bge_tcnt", taken_cnt, 32'd2);

    // Wait timeout after MAX_WAIT stall cycles
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 3'b000, 1, 0, 1, 0);
      chk("to_stall", 32'(o1), 32'b100000);
    end
    drive(1, 0, 3'b000, 1, 0, 1, 0);
    chk("to_hazard", 32'(o1), 32'b000010);
    drive(0, 0, 3'b000, 0, 0, 0, 0);
    chk("to_idle", 32'(o1), 32'b000000);
    chk("to_bcnt", branch_cnt, 32'd5);
    chk("to_tcnt", taken_cnt, 32'd2);
    chk("to_scnt", stall_cnt, 32'd6);

    // Illegal funct3 pulse
    drive(1, 0, 3'b011, 0, 0, 1, 0);
    chk("ill_pulse", 32'(o1), 32'b000101);
    drive(0, 0, 3'b000, 0, 0, 0, 0);
    chk("ill_clear", 32'(o1), 32'b000000);
    chk("ill_bcnt", branch_cnt, 32'd6);

    // JAL during FLUSH is ignored
    drive(0, 1, 3'b000, 0, 0, 0, 0);
    chk("jal_taken", 32'(o1), 32'b011000);
    drive(0, 1, 3'b000, 0, 0, 0, 0);
    chk("jal_in_flush", 32'(o1), 32'b001000);
    drive(0, 0, 3'b000, 0, 0, 0, 0);
    chk("jal_idle", 32'(o1), 32'b000000);
    chk("jal_bcnt", branch_cnt, 32'd7);
    chk("jal_tcnt", taken_cnt, 32'd3);

    // Kill during WAIT
    drive(1, 0, 3'b000, 1, 0, 0, 0);
    chk("kw_stall", 32'(o1), 32'b100000);
    drive(1, 0, 3'b000, 1, 0, 0, 1);
    chk("kw_kill", 32'(o1), 32'b001000);
    drive(0, 0, 3'b000, 0, 0, 0, 0);
    chk("kw_idle", 32'(o1), 32'b000000);
    chk("kw_scnt", stall_cnt, 32'd7);
    chk("kw_bcnt", branch_cnt, 32'd7);

    // Kill beats a resolving jump
    drive(0, 1, 3'b000, 0, 0, 0, 1);
    chk("kj_kill", 32'(o1), 32'b001000);
    drive(0, 0, 3'b000, 0, 0, 0, 0);
    chk("kj_idle", 32'(o1), 32'b000000);
    chk("kj_bcnt", branch_cnt, 32'd7);
    chk("kj_tcnt", taken_cnt, 32'd3);

    // Async reset in the middle of FLUSH
    drive(0, 1, 3'b000, 0, 0, 0, 0);
    drive(0, 0, 3'b000, 0, 0, 0, 0);
    chk("rf_flush", 32'(o1), 32'b001000);
    chk("rf_tcnt_pre", taken_cnt, 32'd4);
    #1 rst = 1'b1;
    #1;
    chk("rf_outs", 32'(o1), 32'b000000);
    chk("rf_bcnt", branch_cnt, 32'd0);
    chk("rf_tcnt", taken_cnt, 32'd0);
    chk("rf_scnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 3'b000, 0, 0, 0, 0);
    chk("rf_idle", 32'(o1), 32'b000000);

    // Saturation on the 4-bit instance with back-to-back jumps
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      j2 = 1'b1;
      #1;
      if (i == 0) chk("sat_first", 32'(o2), 32'b011000);
    end
    @(negedge clk);
    j2 = 1'b0;
    #1;
    chk("sat_outs", 32'(o2), 32'b000000);
    chk("sat_tcnt", 32'(taken_cnt2), 32'd15);
    chk("sat_bcnt", 32'(branch_cnt2), 32'd15);
    chk("sat_scnt", 32'(stall_cnt2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/br_ctrl.md
Name: br_ctrl

Overview:
- Branch-resolution controller in the EX stage of the stalling RISC-V pipeline; sequences the shared `brcomp` comparator.
- Decodes `funct3` and drives `br_unsigned`, then turns `br_less`/`br_equal` into a taken/not-taken decision.
- Stalls while a branch operand is still in flight (load-use), and redirects the PC and flushes the front end for a programmable number of cycles.
- Keeps saturating performance counters. Static predict-not-taken.

Parameters:
- FLUSH_CYCLES, 2, cycles `flush_o` stays high after a taken branch/jump (range 1..7).
- MAX_WAIT, 4, maximum consecutive operand-wait cycles before `hazard_err_o` (range 1..15).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- br_valid_i  in  1  conditional branch present in EX.
- jump_i  in  1  JAL/JALR present in EX; always taken; exclusive with `br_valid_i`.
- funct3_i  in  3  branch `funct3`.
- opnd_busy_i  in  1  rs1/rs2 value not yet forwardable.
- kill_i  in  1  external trap/flush; overrides everything.
- br_less_i  in  1  from `brcomp`.
- br_equal_i  in  1  from `brcomp`.
- br_unsigned_o  out  1  to `brcomp`.
- stall_o  out  1  freeze PC, IF/ID and ID/EX.
- pc_sel_o  out  1  select branch target.
- flush_o  out  1  squash IF/ID and ID/EX.
- illegal_o  out  1  one-cycle pulse for `funct3` 010/011.
- hazard_err_o  out  1  one-cycle pulse on wait timeout.
- branch_cnt_o  out  CNT_W  resolved branches and jumps.
- taken_cnt_o  out  CNT_W  taken branches and jumps.
- stall_cnt_o  out  CNT_W  cycles with `stall_o` = 1.

Behaviour:
- Reset (async, `rst` = 1):
  - State goes to IDLE; the wait and flush counters clear.
  - All 1-bit outputs are 0 and all counters are 0.
  - Reset mid-WAIT or mid-FLUSH aborts with no pulse.
- `br_unsigned_o` is combinational: `funct3_i[1]`. This is valid whenever `br_valid_i` = 1.
- Condition table (`funct3`: taken when):
  - 000: `br_equal_i`; 001: `!br_equal_i`.
  - 100 and 110: `br_less_i`; 101 and 111: `!br_less_i`.
  - 010/011: never taken, and `illegal_o` pulses in the resolving cycle.
- States: IDLE, WAIT, FLUSH.
- IDLE:
  - If (`br_valid_i` | `jump_i`) and `opnd_busy_i` = 1: `stall_o` = 1 comb, go to WAIT, wait count = 1. Jumps also wait, because JALR needs rs1.
  - If (`br_valid_i` | `jump_i`) and `opnd_busy_i` = 0: resolve this cycle (comb).
    - Increment `branch_cnt`.
    - If taken: `pc_sel_o` = 1 and `flush_o` = 1 this cycle, increment `taken_cnt`. If FLUSH_CYCLES > 1, go to FLUSH with remaining = FLUSH_CYCLES-1; otherwise stay in IDLE.
    - If not taken: no stall, stay in IDLE.
- WAIT:
  - `stall_o` = 1 while `opnd_busy_i` = 1, and wait count increments.
  - When `opnd_busy_i` = 0: `stall_o` = 0 and the branch resolves this cycle exactly as in IDLE.
  - When wait count would exceed MAX_WAIT: `hazard_err_o` pulses, the branch resolves as not taken (counted in `branch_cnt`), `stall_o` = 0, go to IDLE.
- FLUSH:
  - `flush_o` = 1, `pc_sel_o` = 0, `stall_o` = 0.
  - `br_valid_i`/`jump_i` are ignored, because the instruction is being squashed.
  - Remaining count decrements; go to IDLE when it reaches 0.
  - Total `flush_o` high = FLUSH_CYCLES cycles, including the resolve cycle.
- `kill_i` = 1 in any state:
  - `pc_sel_o`, `stall_o` and `illegal_o`/`hazard_err_o` forced to 0; `flush_o` = 1; next state IDLE; counters not incremented that cycle.
  - `kill_i` together with a resolving branch: the kill wins.
- `br_valid_i` and `jump_i` both 1: treated as a jump and taken; an `assert` flags the violation.
- Counters saturate at all-ones and never wrap.
- `stall_cnt` increments every cycle `stall_o` = 1.
- Outputs are comb from state and inputs; only state and counters are registered. There are no combinational loops, since `brcomp` inputs do not depend on `stall_o`.

Decomposition:
- Package `br_pkg` holds:
  - `funct3` localparams: F3_BEQ = 000, F3_BNE = 001, F3_BLT = 100, F3_BGE = 101, F3_BLTU = 110, F3_BGEU = 111.
  - The `br_state_t` enum {IDLE, WAIT, FLUSH}.
  - Function `br_taken(funct3, less, equal)`.
- Sub-module `sat_counter` (param W; inputs `inc`, `clr` via `rst`): instantiated three times.

Test Plan:
- BEQ, `funct3` = 000, `opnd_busy_i` = 0, `br_equal_i` = 1 -> same cycle: `pc_sel_o` = 1, `flush_o` = 1; `flush_o` also high the next cycle (2 total); `branch_cnt` = 1, `taken_cnt` = 1.
- BLTU, `funct3` = 110 -> `br_unsigned_o` = 1; with `br_less_i` = 0 -> not taken, `flush_o` = 0, `stall_o` = 0; BLT (100) -> `br_unsigned_o` = 0.
- BGE with `opnd_busy_i` = 1 for 2 cycles, then 0 with `br_less_i` = 0 -> `stall_o` = 1 for 2 cycles, taken in the 3rd cycle; `stall_cnt` = 2.
- `opnd_busy_i` held at 1, MAX_WAIT = 4 -> `stall_o` high for 4 cycles, `hazard_err_o` pulses in the 5th cycle, returns to IDLE, `branch_cnt` increments and `taken_cnt` does not.
- `funct3` = 011 -> `illegal_o` = 1 for one cycle, not taken; JAL during FLUSH is ignored; `kill_i` during WAIT -> `stall_o` = 0 and `flush_o` = 1 that cycle, IDLE next cycle.
- Async `rst` pulse mid-FLUSH -> immediately all outputs 0 and counters 0; preload CNT_W = 4 and run 20 taken jumps -> `taken_cnt_o` = 15 (saturated).
